// File: rtl/rv32v_types_pkg.sv
// Shared vector-unit types: element offsets, compress write-back entries and FSM states.
package rv32v_types_pkg;

  localparam int unsigned CWB_OFF_W  = 5;
  localparam int unsigned CWB_DATA_W = 32;

  typedef logic [CWB_OFF_W-1:0] offset_t;

  typedef struct packed {
    offset_t               off;
    logic [CWB_DATA_W-1:0] dat;
  } cwb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } cwb_state_t;

endpackage

// File: rtl/compress_wb_buffer_if.sv
// Bundle of compress write-back signals with views for the buffer, offset unit and VRF.
interface compress_wb_buffer_if #(
  parameter int unsigned OFF_W  = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input logic CLK,
  input logic nRST
);
  logic              ena;
  logic [1:0]        wen;
  logic [OFF_W-1:0]  woffset0;
  logic [OFF_W-1:0]  woffset1;
  logic [DATA_W-1:0] wdat0;
  logic [DATA_W-1:0] wdat1;
  logic              up_done;
  logic              stall;
  logic              vrf_wen;
  logic [OFF_W-1:0]  vrf_woffset;
  logic [DATA_W-1:0] vrf_wdata;
  logic              vrf_ready;
  logic              busy;
  logic              drain_done;
  logic [CNT_W-1:0]  wr_count;

  modport cwb (
    input  CLK, nRST, ena, wen, woffset0, woffset1, wdat0, wdat1, up_done, vrf_ready,
    output stall, vrf_wen, vrf_woffset, vrf_wdata, busy, drain_done, wr_count
  );

  modport ofs (
    input  CLK, nRST, stall, busy, drain_done, wr_count,
    output ena, wen, woffset0, woffset1, wdat0, wdat1, up_done
  );

  modport vrf (
    input  CLK, nRST, vrf_wen, vrf_woffset, vrf_wdata,
    output vrf_ready
  );
endinterface

// File: rtl/cwb_fifo2w1r.sv
// Dual-write / single-read FIFO; caller compacts pushes so wdata0 is always the first entry.
module cwb_fifo2w1r #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 37,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    push_n,
  input  logic [W-1:0]  wdata0,
  input  logic [W-1:0]  wdata1,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [PW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [PW-1:0] wptr_nxt;

  always_comb begin
    mem_d    = mem_q;
    wptr_nxt = wptr_q + PW'(1);
    if (push_n != 2'd0) mem_d[wptr_q[AW-1:0]]   = wdata0;
    if (push_n == 2'd2) mem_d[wptr_nxt[AW-1:0]] = wdata1;
    wptr_d  = wptr_q + PW'(push_n);
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + PW'(push_n) - PW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rptr_q[AW-1:0]];
  assign count = count_q;
endmodule

// File: rtl/compress_wb_buffer.sv
// Compress write-back buffer: queues up to two offset/data pairs per cycle and drains one per cycle to the VRF.
// Optional COMPRESS_WB_PROTO_CHK_EN adds a sticky proto_err output flagging dropped pushes and stray ena.
module compress_wb_buffer
  import rv32v_types_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = 5,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ena,
  input  logic [1:0]        wen,
  input  logic [OFF_W-1:0]  woffset0,
  input  logic [OFF_W-1:0]  woffset1,
  input  logic [DATA_W-1:0] wdat0,
  input  logic [DATA_W-1:0] wdat1,
  input  logic              up_done,
  output logic              stall,
  output logic              vrf_wen,
  output logic [OFF_W-1:0]  vrf_woffset,
  output logic [DATA_W-1:0] vrf_wdata,
  input  logic              vrf_ready,
  output logic              busy,
  output logic              drain_done,
`ifdef COMPRESS_WB_PROTO_CHK_EN
  output logic              proto_err,
`endif
  output logic [CNT_W-1:0]  wr_count
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = OFF_W + DATA_W;

  cwb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [PW-1:0]     fifo_count;
  logic [EW-1:0]     head, entry0, entry1;
  logic [1:0]        wen_eff, push_n;
  logic              push_ok, pop;

  assign stall   = fifo_count > PW'(DEPTH - 2);
  assign vrf_wen = fifo_count != '0;
  assign pop     = vrf_wen && vrf_ready;
  assign push_ok = (state_q == ACTIVE) && !stall;
  assign wen_eff = push_ok ? wen : 2'b00;
  assign push_n  = {1'b0, wen_eff[0]} + {1'b0, wen_eff[1]};

  // A lone slot-1 push is shifted into the first write lane so the FIFO only ever fills from lane 0 up.
  assign entry0 = wen_eff[0] ? {woffset0, wdat0} : {woffset1, wdat1};
  assign entry1 = {woffset1, wdat1};

  cwb_fifo2w1r #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk    (CLK),
    .rst_n  (nRST),
    .push_n (push_n),
    .wdata0 (entry0),
    .wdata1 (entry1),
    .pop    (pop),
    .head   (head),
    .count  (fifo_count)
  );

  assign {vrf_woffset, vrf_wdata} = head;

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE:    if (ena) state_d = ACTIVE;
      ACTIVE:  if (up_done) state_d = DRAIN;
      DRAIN:   if (fifo_count == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q == IDLE) && ena) wr_count_d = '0;
    else if (pop && (wr_count_q != '1)) wr_count_d = wr_count_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign busy       = state_q != IDLE;
  assign drain_done = state_q == DONE;
  assign wr_count   = wr_count_q;

`ifdef COMPRESS_WB_PROTO_CHK_EN
  logic proto_err_q, proto_err_d;

  always_comb begin
    proto_err_d = proto_err_q;
    if ((state_q == IDLE) && ena) proto_err_d = 1'b0;
    if (((wen != 2'b00) && (stall || (state_q != ACTIVE))) || (ena && (state_q != IDLE)))
      proto_err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) proto_err_q <= 1'b0;
    else       proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;
`endif
endmodule

// File: tb/tb_compress_wb_buffer.sv
// Directed self-checking bench for compress_wb_buffer (DEPTH=4, DATA_W=32, OFF_W=5, CNT_W=6).
module tb_compress_wb_buffer;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        ena, up_done, vrf_ready;
  logic [1:0]  wen;
  logic [4:0]  woffset0, woffset1;
  logic [31:0] wdat0, wdat1;
  logic        stall, vrf_wen, busy, drain_done;
  logic [4:0]  vrf_woffset;
  logic [31:0] vrf_wdata;
  logic [5:0]  wr_count;
`ifdef COMPRESS_WB_PROTO_CHK_EN
  logic        proto_err;
`endif

  int errors = 0;
  int checks = 0;

  compress_wb_buffer #(
    .DEPTH  (4),
    .DATA_W (32),
    .OFF_W  (5),
    .CNT_W  (6)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ena         (ena),
    .wen         (wen),
    .woffset0    (woffset0),
    .woffset1    (woffset1),
    .wdat0       (wdat0),
    .wdat1       (wdat1),
    .up_done     (up_done),
    .stall       (stall),
    .vrf_wen     (vrf_wen),
    .vrf_woffset (vrf_woffset),
    .vrf_wdata   (vrf_wdata),
    .vrf_ready   (vrf_ready),
    .busy        (busy),
    .drain_done  (drain_done),
`ifdef COMPRESS_WB_PROTO_CHK_EN
    .proto_err   (proto_err),
`endif
    .wr_count    (wr_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; ena = 0; up_done = 0; vrf_ready = 0; wen = 2'b00;
    woffset0 = '0; woffset1 = '0; wdat0 = '0; wdat1 = '0;
    #12;
    checks++; if ({stall, vrf_wen, busy, drain_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {stall, vrf_wen, busy, drain_done}); end
    checks++; if ({vrf_woffset, vrf_wdata, wr_count} !== 43'd0) begin
      errors++; $display("FAIL reset_data: got off=%0d dat=%h cnt=%0d expected all 0", vrf_woffset, vrf_wdata, wr_count); end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    ena = 1; tick(); ena = 0;
    checks++; if (busy !== 1'b1 || wr_count !== 6'd0) begin
      errors++; $display("FAIL single_start: got busy=%b cnt=%0d expected busy=1 cnt=0", busy, wr_count); end
    wen = 2'b01; woffset0 = 5'd3; wdat0 = 32'hAA; vrf_ready = 1; tick();
    woffset0 = 5'd7; wdat0 = 32'hBB;
    checks++; if (vrf_wen !== 1'b1 || vrf_woffset !== 5'd3 || vrf_wdata !== 32'hAA) begin
      errors++; $display("FAIL single_first: got wen=%b off=%0d dat=%h expected 1/3/aa", vrf_wen, vrf_woffset, vrf_wdata); end
    tick(); wen = 2'b00;
    checks++; if (vrf_wen !== 1'b1 || vrf_woffset !== 5'd7 || vrf_wdata !== 32'hBB) begin
      errors++; $display("FAIL single_second: got wen=%b off=%0d dat=%h expected 1/7/bb", vrf_wen, vrf_woffset, vrf_wdata); end
    tick();
    checks++; if (vrf_wen !== 1'b0 || wr_count !== 6'd2) begin
      errors++; $display("FAIL single_empty: got wen=%b cnt=%0d expected 0/2", vrf_wen, wr_count); end
    up_done = 1; tick(); up_done = 0;
    checks++; if (busy !== 1'b1 || drain_done !== 1'b0) begin
      errors++; $display("FAIL single_drain: got busy=%b done=%b expected 1/0", busy, drain_done); end
    tick();
    checks++; if (drain_done !== 1'b1) begin
      errors++; $display("FAIL single_done_pulse: got %b expected 1", drain_done); end
    tick();
    checks++; if (drain_done !== 1'b0 || busy !== 1'b0 || wr_count !== 6'd2) begin
      errors++; $display("FAIL single_idle: got done=%b busy=%b cnt=%0d expected 0/0/2", drain_done, busy, wr_count); end
  endtask

  task automatic test_dual_write();
    ena = 1; tick(); ena = 0;
    wen = 2'b11; woffset0 = 5'd2; wdat0 = 32'h11; woffset1 = 5'd5; wdat1 = 32'h22; vrf_ready = 1;
    tick(); wen = 2'b00;
    checks++; if (vrf_woffset !== 5'd2 || vrf_wdata !== 32'h11) begin
      errors++; $display("FAIL dual_slot0: got off=%0d dat=%h expected 2/11", vrf_woffset, vrf_wdata); end
    tick();
    checks++; if (vrf_wen !== 1'b1 || vrf_woffset !== 5'd5 || vrf_wdata !== 32'h22) begin
      errors++; $display("FAIL dual_slot1: got wen=%b off=%0d dat=%h expected 1/5/22", vrf_wen, vrf_woffset, vrf_wdata); end
    tick();
    wen = 2'b10; woffset0 = 5'd9; wdat0 = 32'h33; woffset1 = 5'd6; wdat1 = 32'h44;
    tick(); wen = 2'b00;
    checks++; if (vrf_wen !== 1'b1 || vrf_woffset !== 5'd6 || vrf_wdata !== 32'h44) begin
      errors++; $display("FAIL dual_only_slot1: got wen=%b off=%0d dat=%h expected 1/6/44", vrf_wen, vrf_woffset, vrf_wdata); end
    tick();
    checks++; if (vrf_wen !== 1'b0 || wr_count !== 6'd3) begin
      errors++; $display("FAIL dual_count: got wen=%b cnt=%0d expected 0/3", vrf_wen, wr_count); end
    up_done = 1; tick(); up_done = 0; tick(); tick();
  endtask

  task automatic test_back_to_back();
    ena = 1; tick(); ena = 0; vrf_ready = 0;
    wen = 2'b11; woffset0 = 5'd1; wdat0 = 32'hA1; woffset1 = 5'd2; wdat1 = 32'hA2; tick();
    checks++; if (stall !== 1'b0 || vrf_woffset !== 5'd1) begin
      errors++; $display("FAIL bp_two: got stall=%b off=%0d expected 0/1", stall, vrf_woffset); end
    woffset0 = 5'd3; wdat0 = 32'hA3; woffset1 = 5'd4; wdat1 = 32'hA4; tick();
    checks++; if (stall !== 1'b1 || vrf_woffset !== 5'd1) begin
      errors++; $display("FAIL bp_full: got stall=%b off=%0d expected 1/1", stall, vrf_woffset); end
    woffset0 = 5'd5; wdat0 = 32'hA5; woffset1 = 5'd6; wdat1 = 32'hA6; tick(); wen = 2'b00;
    checks++; if (stall !== 1'b1 || vrf_woffset !== 5'd1 || vrf_wdata !== 32'hA1) begin
      errors++; $display("FAIL bp_hold: got stall=%b off=%0d dat=%h expected 1/1/a1", stall, vrf_woffset, vrf_wdata); end
    vrf_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (vrf_wen !== 1'b1 || vrf_woffset !== 5'(i + 1) || vrf_wdata !== 32'hA1 + 32'(i)) begin
        errors++; $display("FAIL bp_order[%0d]: got wen=%b off=%0d dat=%h expected 1/%0d/%h", i, vrf_wen, vrf_woffset, vrf_wdata, i + 1, 32'hA1 + 32'(i)); end
      tick();
      if (i == 0) begin
        checks++; if (stall !== 1'b1) begin
          errors++; $display("FAIL bp_stall_at3: got %b expected 1", stall); end
      end
    end
    checks++; if (vrf_wen !== 1'b0 || wr_count !== 6'd4) begin
      errors++; $display("FAIL bp_empty: got wen=%b cnt=%0d expected 0/4", vrf_wen, wr_count); end
    // push and pop together with two entries buffered
    vrf_ready = 0; wen = 2'b11; woffset0 = 5'd10; wdat0 = 32'h10; woffset1 = 5'd11; wdat1 = 32'h11; tick();
    wen = 2'b01; woffset0 = 5'd12; wdat0 = 32'h12; vrf_ready = 1; tick();
    wen = 2'b00; vrf_ready = 0;
    checks++; if (stall !== 1'b0 || vrf_wen !== 1'b1 || vrf_woffset !== 5'd11) begin
      errors++; $display("FAIL pp_count2: got stall=%b wen=%b off=%0d expected 0/1/11", stall, vrf_wen, vrf_woffset); end
    vrf_ready = 1; tick();
    checks++; if (vrf_woffset !== 5'd12 || vrf_wdata !== 32'h12) begin
      errors++; $display("FAIL pp_next: got off=%0d dat=%h expected 12/12", vrf_woffset, vrf_wdata); end
    tick();
    checks++; if (vrf_wen !== 1'b0 || wr_count !== 6'd7) begin
      errors++; $display("FAIL pp_total: got wen=%b cnt=%0d expected 0/7", vrf_wen, wr_count); end
    up_done = 1; tick(); up_done = 0; tick();
    checks++; if (drain_done !== 1'b1) begin
      errors++; $display("FAIL bp_done: got %b expected 1", drain_done); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    ena = 1; tick(); ena = 0; vrf_ready = 0;
    wen = 2'b11; woffset0 = 5'd1; wdat0 = 32'hC1; woffset1 = 5'd2; wdat1 = 32'hC2; tick();
    wen = 2'b01; woffset0 = 5'd3; wdat0 = 32'hC3; tick();
    wen = 2'b00; up_done = 1; tick(); up_done = 0;
    checks++; if (busy !== 1'b1 || vrf_wen !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got busy=%b wen=%b stall=%b expected 1/1/1", busy, vrf_wen, stall); end
    #2 nRST = 1'b0;
    #1;
    checks++; if ({stall, vrf_wen, busy, drain_done, vrf_woffset, vrf_wdata, wr_count} !== 47'd0) begin
      errors++; $display("FAIL mid_async: got stall=%b wen=%b busy=%b off=%0d dat=%h expected all 0", stall, vrf_wen, busy, vrf_woffset, vrf_wdata); end
    vrf_ready = 1;
    #1 nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (vrf_wen !== 1'b0 || busy !== 1'b0 || wr_count !== 6'd0) begin
        errors++; $display("FAIL mid_after[%0d]: got wen=%b busy=%b cnt=%0d expected 0/0/0", i, vrf_wen, busy, wr_count); end
    end
  endtask

`ifdef COMPRESS_WB_PROTO_CHK_EN
  task automatic test_proto_err();
    ena = 1; tick(); ena = 0; vrf_ready = 0;
    wen = 2'b11; tick(); tick();
    wen = 2'b01; tick(); wen = 2'b00;
    checks++; if (proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_set: got %b expected 1", proto_err); end
    vrf_ready = 1; tick(); tick(); tick(); tick();
    up_done = 1; tick(); up_done = 0; tick(); tick();
    checks++; if (proto_err !== 1'b1) begin
      errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
    ena = 1; tick(); ena = 0;
    checks++; if (proto_err !== 1'b0) begin
      errors++; $display("FAIL proto_clear: got %b expected 0", proto_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_dual_write();
    test_back_to_back();
    test_reset_mid_drain();
`ifdef COMPRESS_WB_PROTO_CHK_EN
    test_proto_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
